// File: rtl/ff_pkg.sv
// Shared constants and FSM encoding for the JPEG bitstream packer.
package ff_pkg;

  localparam logic [7:0] BYTE_FF    = 8'hFF;
  localparam logic [7:0] BYTE_STUFF = 8'h00;
  localparam logic [7:0] EOI_LO     = 8'hD9;

  typedef enum logic [2:0] {
    RUN,
    PAD,
    EOI_FF,
    EOI_D9,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/ff_stuff_packer_if.sv
// Codeword stream from the Huffman coder into the packer.
interface ff_stuff_packer_if #(
  parameter int CODE_W = 32
) ();

  localparam int LEN_W = $clog2(CODE_W + 1);

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic [LEN_W-1:0]  in_len;
  logic              in_last;

  modport master (output in_valid, in_code, in_len, in_last, input in_ready);
  modport slave  (input in_valid, in_code, in_len, in_last, output in_ready);

endinterface

// File: rtl/ff_word_assembler.sv
// Packs bytes into SRAM words (lane 0 = lowest byte address) and owns the
// registered SRAM write port, address saturation and the overflow flag.
module ff_word_assembler #(
  parameter int SRAM_DW   = 32,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic                 flush,
  input  logic                 frame_done,
  input  logic                 frame_start,
  output logic [SRAM_DW-1:0]   sram_data,
  output logic [SRAM_DW/8-1:0] sram_we,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic                 overflow
);

  localparam int NB     = SRAM_DW / 8;
  localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

  logic [SRAM_DW-1:0] word_q;
  logic [LANE_W-1:0]  lane;
  logic               word_full;
  logic               full_q;

  logic [NB-1:0]      part_we;
  logic [SRAM_DW-1:0] part_data;
  logic               wr_req;
  logic               wr_blocked;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    part_we   = '0;
    part_data = '0;
    for (int i = 0; i < NB; i++) begin
      part_we[i] = (i < int'(lane));
      if (part_we[i]) part_data[i*8 +: 8] = word_q[i*8 +: 8];
    end
    wr_req     = word_full || (flush && lane != '0);
    // A write issued this cycle at the top address saturates the SRAM as of the next edge.
    wr_blocked = full_q || ((|sram_we) && sram_addr == MAX_ADDR);
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q    <= '0;
      lane      <= '0;
      word_full <= 1'b0;
      full_q    <= 1'b0;
      sram_data <= '0;
      sram_we   <= '0;
      sram_addr <= ADDR_W'(BASE_ADDR);
      overflow  <= 1'b0;
    end else begin
      sram_we   <= '0;
      sram_data <= '0;
      word_full <= 1'b0;

      if (byte_valid) begin
        word_q[lane*8 +: 8] <= byte_data;
        if (lane == LANE_W'(NB - 1)) begin
          lane      <= '0;
          word_full <= 1'b1;
        end else begin
          lane <= lane + 1'b1;
        end
      end

      if (frame_start) overflow <= 1'b0;

      if (wr_req) begin
        if (wr_blocked) begin
          overflow <= 1'b1;
        end else begin
          sram_we   <= word_full ? '1 : part_we;
          sram_data <= word_full ? word_q : part_data;
        end
        if (!word_full) lane <= '0;
      end

      if (frame_done) begin
        sram_addr <= ADDR_W'(BASE_ADDR);
        full_q    <= 1'b0;
        lane      <= '0;
      end else if (|sram_we) begin
        if (sram_addr == MAX_ADDR) full_q <= 1'b1;
        else                       sram_addr <= sram_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ff_stuff_packer.sv
// Packs variable-length Huffman codewords MSB-first into a JPEG byte stream with
// 0xFF stuffing, 1-padding and optional EOI, then hands bytes to the word assembler.
module ff_stuff_packer
  import ff_pkg::*;
#(
  parameter int CODE_W    = 32,
  parameter int SRAM_DW   = 32,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int EOI_EN    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  ff_stuff_packer_if.slave                     cw,
  output logic [SRAM_DW-1:0]                   sram_data,
  output logic [SRAM_DW/8-1:0]                 sram_we,
  output logic [ADDR_W-1:0]                    sram_addr,
  output logic                                 last_to_cpu,
  output logic [ADDR_W+$clog2(SRAM_DW/8)-1:0]  byte_count,
  output logic                                 overflow
);

  localparam int ACC_W  = CODE_W + 7;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam state_t PAD_NEXT = (EOI_EN != 0) ? EOI_FF : FLUSH;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [FILL_W-1:0] fill;
  logic              stuff_pend;
  logic              last_seen;
  logic              new_frame;
  logic              live;

  logic [ACC_W-1:0]  mask;
  logic [ACC_W-1:0]  ins_bits;
  int                len_c;
  logic              accept;
  logic              emit_valid;
  logic              set_stuff;
  logic [7:0]        emit_byte;
  logic [7:0]        top_byte;
  logic [7:0]        pad_byte;

  // Valid bits sit left-aligned in acc; everything below them is kept zero.
  assign top_byte    = acc[ACC_W-1 -: 8];
  assign pad_byte    = top_byte | (8'hFF >> fill);
  assign cw.in_ready = live && state == RUN && fill < FILL_W'(8) && !stuff_pend && !last_seen;
  assign accept      = cw.in_valid && cw.in_ready;

  always_comb begin
    len_c    = (int'(cw.in_len) > CODE_W) ? CODE_W : int'(cw.in_len);
    mask     = {ACC_W{1'b1}} >> (ACC_W - len_c);
    ins_bits = (ACC_W'(cw.in_code) & mask) << (ACC_W - int'(fill) - len_c);
  end

  always_comb begin
    emit_valid = 1'b0;
    emit_byte  = BYTE_STUFF;
    set_stuff  = 1'b0;
    case (state)
      RUN: begin
        if (stuff_pend) begin
          emit_valid = 1'b1;
        end else if (fill >= FILL_W'(8)) begin
          emit_valid = 1'b1;
          emit_byte  = top_byte;
          set_stuff  = (top_byte == BYTE_FF);
        end
      end
      PAD: begin
        if (stuff_pend) begin
          emit_valid = 1'b1;
        end else if (fill != '0) begin
          emit_valid = 1'b1;
          emit_byte  = pad_byte;
          set_stuff  = (pad_byte == BYTE_FF);
        end
      end
      EOI_FF: begin
        emit_valid = 1'b1;
        emit_byte  = BYTE_FF;
      end
      EOI_D9: begin
        emit_valid = 1'b1;
        emit_byte  = EOI_LO;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      acc         <= '0;
      fill        <= '0;
      stuff_pend  <= 1'b0;
      last_seen   <= 1'b0;
      new_frame   <= 1'b1;
      live        <= 1'b0;
      byte_count  <= '0;
      last_to_cpu <= 1'b0;
    end else begin
      live        <= 1'b1;
      last_to_cpu <= 1'b0;
      if (emit_valid) byte_count <= byte_count + 1'b1;
      if (accept && new_frame) begin
        byte_count <= '0;
        new_frame  <= 1'b0;
      end

      case (state)
        RUN: begin
          if (accept) begin
            acc  <= acc | ins_bits;
            fill <= fill + FILL_W'(len_c);
            if (cw.in_last) last_seen <= 1'b1;
          end else if (emit_valid) begin
            if (stuff_pend) begin
              stuff_pend <= 1'b0;
            end else begin
              acc        <= acc << 8;
              fill       <= fill - FILL_W'(8);
              stuff_pend <= set_stuff;
            end
          end else if (last_seen) begin
            state <= PAD;
          end
        end
        PAD: begin
          if (stuff_pend) begin
            stuff_pend <= 1'b0;
            state      <= PAD_NEXT;
          end else if (fill != '0) begin
            acc        <= '0;
            fill       <= '0;
            stuff_pend <= set_stuff;
            if (!set_stuff) state <= PAD_NEXT;
          end else begin
            state <= PAD_NEXT;
          end
        end
        EOI_FF: state <= EOI_D9;
        EOI_D9: state <= FLUSH;
        FLUSH:  state <= DONE;
        DONE: begin
          last_to_cpu <= 1'b1;
          last_seen   <= 1'b0;
          new_frame   <= 1'b1;
          state       <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  ff_word_assembler #(
    .SRAM_DW   (SRAM_DW),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_word_assembler (
    .clk         (clk),
    .rst         (rst),
    .byte_valid  (emit_valid),
    .byte_data   (emit_byte),
    .flush       (state == FLUSH),
    .frame_done  (state == DONE),
    .frame_start (accept && new_frame),
    .sram_data   (sram_data),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .overflow    (overflow)
  );

endmodule

// File: tb/tb_ff_stuff_packer.sv
// Directed bench: three packer instances (EOI on, EOI off, tiny SRAM) with logged SRAM writes.
module tb_ff_stuff_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ff_stuff_packer_if #(.CODE_W(32)) if_a ();
  ff_stuff_packer_if #(.CODE_W(32)) if_b ();
  ff_stuff_packer_if #(.CODE_W(32)) if_c ();

  logic [31:0] data_a, data_b, data_c;
  logic [3:0]  we_a, we_b, we_c;
  logic [11:0] addr_a, addr_b;
  logic [1:0]  addr_c;
  logic        last_a, last_b, last_c;
  logic [13:0] bc_a, bc_b;
  logic [3:0]  bc_c;
  logic        ovf_a, ovf_b, ovf_c;

  ff_stuff_packer #(.EOI_EN(1)) u_a (
    .clk(clk), .rst(rst), .cw(if_a), .sram_data(data_a), .sram_we(we_a),
    .sram_addr(addr_a), .last_to_cpu(last_a), .byte_count(bc_a), .overflow(ovf_a));
  ff_stuff_packer #(.EOI_EN(0)) u_b (
    .clk(clk), .rst(rst), .cw(if_b), .sram_data(data_b), .sram_we(we_b),
    .sram_addr(addr_b), .last_to_cpu(last_b), .byte_count(bc_b), .overflow(ovf_b));
  ff_stuff_packer #(.ADDR_W(2), .EOI_EN(0)) u_c (
    .clk(clk), .rst(rst), .cw(if_c), .sram_data(data_c), .sram_we(we_c),
    .sram_addr(addr_c), .last_to_cpu(last_c), .byte_count(bc_c), .overflow(ovf_c));

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
    int          cyc;
  } wr_t;

  wr_t log_a[$];
  wr_t log_b[$];
  wr_t log_c[$];
  int  done_cnt[3];
  int  done_cyc[3];

  initial for (int i = 0; i < 3; i++) begin
    done_cnt[i] = 0;
    done_cyc[i] = 0;
  end

  always @(negedge clk) begin
    if (|we_a) log_a.push_back('{addr_a, data_a, we_a, cyc});
    if (|we_b) log_b.push_back('{addr_b, data_b, we_b, cyc});
    if (|we_c) log_c.push_back('{12'(addr_c), data_c, we_c, cyc});
    if (last_a) begin done_cnt[0]++; done_cyc[0] = cyc; end
    if (last_b) begin done_cnt[1]++; done_cyc[1] = cyc; end
    if (last_c) begin done_cnt[2]++; done_cyc[2] = cyc; end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic [31:0] code, input int len,
                       input logic last);
    case (k)
      0: begin if_a.in_valid = v; if_a.in_code = code; if_a.in_len = 6'(len); if_a.in_last = last; end
      1: begin if_b.in_valid = v; if_b.in_code = code; if_b.in_len = 6'(len); if_b.in_last = last; end
      default: begin if_c.in_valid = v; if_c.in_code = code; if_c.in_len = 6'(len); if_c.in_last = last; end
    endcase
  endtask

  function automatic logic rdy(input int k);
    case (k)
      0:       return if_a.in_ready;
      1:       return if_b.in_ready;
      default: return if_c.in_ready;
    endcase
  endfunction

  // Present a codeword and return just after the edge that accepts it.
  task automatic send(input int k, input logic [31:0] code, input int len, input logic last);
    int n;
    step();
    drive(k, 1'b1, code, len, last);
    n = 0;
    while (!rdy(k) && n < 200) begin
      step();
      n++;
    end
    check("send_ready_timeout", 64'(n < 200), 64'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int k);
    step();
    drive(k, 1'b0, 32'h0, 0, 1'b0);
  endtask

  task automatic wait_done(input int k, input int target);
    int n;
    n = 0;
    while (done_cnt[k] < target && n < 300) begin
      step();
      n++;
    end
    check("done_timeout", 64'(done_cnt[k] >= target), 64'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    int rdy_cnt;
    int n0;

    for (int k = 0; k < 3; k++) drive(k, 1'b0, 32'h0, 0, 1'b0);

    // Reset state
    repeat (3) step();
    check("rst_we_a", 64'(we_a), 64'h0);
    check("rst_data_a", 64'(data_a), 64'h0);
    check("rst_addr_a", 64'(addr_a), 64'h0);
    check("rst_last_a", 64'(last_a), 64'h0);
    check("rst_bc_a", 64'(bc_a), 64'h0);
    check("rst_ovf_a", 64'(ovf_a), 64'h0);
    check("rst_ready_a", 64'(if_a.in_ready), 64'h0);
    rst = 1'b1;

    // FF gets stuffed, EOI appended, spill into a second word
    send(0, 32'hFF, 8, 1'b0);
    send(0, 32'h12, 8, 1'b1);
    idle(0);
    wait_done(0, 1);
    check("t1_nwr", 64'(log_a.size()), 64'd2);
    if (log_a.size() >= 2) begin
      check("t1_w0_addr", 64'(log_a[0].addr), 64'h0);
      check("t1_w0_data", 64'(log_a[0].data), 64'hFF1200FF);
      check("t1_w0_we", 64'(log_a[0].we), 64'hF);
      check("t1_w1_addr", 64'(log_a[1].addr), 64'h1);
      check("t1_w1_data", 64'(log_a[1].data), 64'h000000D9);
      check("t1_w1_we", 64'(log_a[1].we), 64'h1);
    end
    check("t1_bc", 64'(bc_a), 64'd5);
    check("t1_addr_back", 64'(addr_a), 64'h0);

    // Back-to-back 32-bit codewords: one accept every five cycles
    base = log_a.size();
    send(0, 32'h12345678, 32, 1'b0);
    rdy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) check("t4_bc_cleared", 64'(bc_a), 64'h0);
      if (if_a.in_ready) rdy_cnt++;
    end
    drive(0, 1'b0, 32'h0, 0, 1'b0);
    check("t4_ready_rate", 64'(rdy_cnt), 64'd4);
    repeat (10) step();
    check("t4_nwr", 64'(log_a.size() - base), 64'd4);
    if (log_a.size() >= base + 2) begin
      check("t4_w0_addr", 64'(log_a[base].addr), 64'h0);
      check("t4_w0_data", 64'(log_a[base].data), 64'h78563412);
      check("t4_w0_we", 64'(log_a[base].we), 64'hF);
      check("t4_w1_addr", 64'(log_a[base+1].addr), 64'h1);
    end

    // Mid-frame reset with two bytes parked in the partial word
    send(0, 32'h0000ABCD, 16, 1'b0);
    idle(0);
    repeat (4) step();
    n0 = log_a.size();
    #2 rst = 1'b0;
    #1;
    check("mrst_we", 64'(we_a), 64'h0);
    check("mrst_data", 64'(data_a), 64'h0);
    check("mrst_addr", 64'(addr_a), 64'h0);
    check("mrst_bc", 64'(bc_a), 64'h0);
    check("mrst_ready", 64'(if_a.in_ready), 64'h0);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    check("mrst_no_write", 64'(log_a.size()), 64'(n0));
    send(0, 32'h55, 8, 1'b1);
    idle(0);
    wait_done(0, 2);
    check("mrst_nwr", 64'(log_a.size()), 64'(n0 + 1));
    if (log_a.size() == n0 + 1) begin
      check("mrst_w_addr", 64'(log_a[n0].addr), 64'h0);
      check("mrst_w_data", 64'(log_a[n0].data), 64'h00D9FF55);
      check("mrst_w_we", 64'(log_a[n0].we), 64'h7);
    end
    check("mrst_bc_frame", 64'(bc_a), 64'd3);

    // No EOI: 3-bit code padded with ones
    send(1, 32'h5, 3, 1'b1);
    idle(1);
    wait_done(1, 1);
    check("t2_nwr", 64'(log_b.size()), 64'd1);
    if (log_b.size() >= 1) begin
      check("t2_addr", 64'(log_b[0].addr), 64'h0);
      check("t2_data", 64'(log_b[0].data), 64'h000000BF);
      check("t2_we", 64'(log_b[0].we), 64'h1);
      check("t2_pulse_after_write", 64'(done_cyc[1] - log_b[0].cyc), 64'd1);
    end

    // Padded byte becomes 0xFF and is stuffed; junk above in_len ignored
    send(1, 32'hABCDEF0F, 4, 1'b1);
    idle(1);
    wait_done(1, 2);
    check("t3_nwr", 64'(log_b.size()), 64'd2);
    if (log_b.size() >= 2) begin
      check("t3_addr", 64'(log_b[1].addr), 64'h0);
      check("t3_data", 64'(log_b[1].data), 64'h000000FF);
      check("t3_we", 64'(log_b[1].we), 64'h3);
    end
    check("t3_bc", 64'(bc_b), 64'd2);

    // Zero-length codeword adds nothing
    send(1, 32'h7, 0, 1'b0);
    send(1, 32'h5A, 8, 1'b1);
    idle(1);
    wait_done(1, 3);
    if (log_b.size() >= 3) check("len0_data", 64'(log_b[2].data), 64'h0000005A);
    check("len0_bc", 64'(bc_b), 64'd1);

    // Four-word SRAM: fifth word dropped and flagged
    for (int i = 0; i < 5; i++) send(2, 32'h11111111, 32, i == 4);
    idle(2);
    wait_done(2, 1);
    check("ovf_nwr", 64'(log_c.size()), 64'd4);
    if (log_c.size() >= 4) begin
      check("ovf_first_addr", 64'(log_c[0].addr), 64'h0);
      check("ovf_last_addr", 64'(log_c[3].addr), 64'h3);
      check("ovf_last_data", 64'(log_c[3].data), 64'h11111111);
    end
    check("ovf_flag", 64'(ovf_c), 64'h1);
    check("ovf_addr_back", 64'(addr_c), 64'h0);
    send(2, 32'h22, 8, 1'b1);
    step();
    check("ovf_cleared", 64'(ovf_c), 64'h0);
    drive(2, 1'b0, 32'h0, 0, 1'b0);
    wait_done(2, 2);
    check("ovf_next_nwr", 64'(log_c.size()), 64'd5);
    if (log_c.size() >= 5) begin
      check("ovf_next_addr", 64'(log_c[4].addr), 64'h0);
      check("ovf_next_data", 64'(log_c[4].data), 64'h00000022);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
